sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Round-robin arbiter sharing one single-port sram_wrapper between NUM_REQ requesters.
//  Accepts at most one read or write per cycle via valid/ready and drives the SRAM addr/data/write_req.
//  Routes each read result back to the port that issued it; reads are pipelined with no bubbles.
//  Sits between the core-side clients (e.g. fetch and load/store) and the shared data SRAM.
// PARAMETERS
//  NUM_REQ    2   number of requester ports (2..8)
//  ADDR_WIDTH 8   SRAM address width; must match the sram_wrapper instance
//  DATA_WIDTH 64  SRAM data width; must match the sram_wrapper instance
// PORTS (per-port buses flattened, port i at [i*W +: W])
//  clk            in   1                    clock, all logic on posedge
//  rst            in   1                    synchronous, active-high reset
//  req_valid      in   NUM_REQ              port i has a request
//  req_write      in   NUM_REQ              1 = write, 0 = read
//  req_addr       in   NUM_REQ*ADDR_WIDTH   request address
//  req_wdata      in   NUM_REQ*DATA_WIDTH   write data (ignored for reads)
//  req_ready      out  NUM_REQ              one-hot grant; transfer = valid & ready
//  resp_valid     out  NUM_REQ              one-hot read-data strobe, 1 cycle
//  resp_rdata     out  DATA_WIDTH           read data, shared by all ports, qualified by resp_valid
//  sram_addr      out  ADDR_WIDTH           to sram_wrapper.addr
//  sram_data      out  DATA_WIDTH           to sram_wrapper.data
//  sram_write_req out  1                    to sram_wrapper.write_req
//  sram_q         in   DATA_WIDTH           from sram_wrapper.q (valid 1 cycle after addr)
// BEHAVIOUR
//  Arbitration (combinational, same cycle):
//  - req_ready[i] = 1 for exactly the first valid port at or after rr_ptr (wrapping modulo NUM_REQ).
//  - req_ready is all-zero when no port is valid; ready never asserts on a non-valid port.
//  - rr_ptr register: on a grant to port g, rr_ptr <= (g+1) mod NUM_REQ; unchanged when idle.
//  - Reset value of rr_ptr is 0.
//  SRAM drive (combinational from grant):
//  - sram_addr/sram_data take the granted port's addr/wdata.
//  - sram_write_req = granted & req_write.
//  - When idle: sram_write_req = 0, addr/data = port 0 values (don't-care, no write).
//  Read return pipeline:
//  - Cycle T: read granted.
//  - T+1: sram_q holds ram[addr]; stage-1 regs record {rd_vld, port id}.
//  - T+2: resp_valid[id] = 1 and resp_rdata <= sram_q registered at T+1 edge.
//  - Fixed read latency is 2 cycles from the accepting edge; one response per cycle max, in issue order.
//  - Writes produce no response.
//  - Write at T then read of the same addr at T+1 returns the new data.
//  - Read and write to the same addr cannot share a cycle (single grant).
//  - Read-during-write is impossible by construction.
//  Reset (rst=1 at a posedge):
//  - rr_ptr=0; stage-1 valid=0; resp_valid=0; resp_rdata=0.
//  - req_ready forced to 0 while rst=1, so sram_write_req=0.
//  - In-flight reads are dropped with no response; SRAM contents are not cleared.
//  Boundary:
//  - All ports valid every cycle: grants rotate 0,1,..,NUM_REQ-1,0,...
//  - Full throughput, no starvation: max wait NUM_REQ-1 cycles.
//  - A port that drops valid before ready loses nothing; requesters must hold addr/wdata/write while valid & !ready.
//  - rr_ptr wraps from NUM_REQ-1 to 0.
// TESTING
//  1 reset: assert rst 2 cycles with all ports valid -> req_ready=0, sram_write_req=0, resp_valid=0 throughout.
//  2 write/read: port0 writes addr 0x10=0xDEADBEEF, next cycle port0 reads 0x10 -> resp_valid[0] 2 cycles after read, resp_rdata=0xDEADBEEF.
//  3 rotation: ports 0 and 1 read 0x01/0x02 continuously -> grants alternate 0,1,0,1; responses routed to matching port, each 2 cycles after its grant.
//  4 pointer: only port1 valid for 1 grant, then both valid -> next grant to port0 (rr_ptr=0 after wrap).
//  5 reset mid-read: grant read at T, rst at T+1 -> no resp_valid at T+2; subsequent reads correct.
//  6 random: 10k cycles random valid/write/addr vs. reference memory model -> every read data and port id matches; no port waits > NUM_REQ-1 cycles.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the shared SRAM arbiter: flattened per-port request
// fields, one-hot grant, one-hot read strobe and shared read data.
interface sram_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters;
// one access per cycle, reads return 2 cycles after grant to the issuing port.
module sram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_arbiter_if.slave         bus,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_write_req,
  input  logic [DATA_WIDTH-1:0] sram_q
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W-1:0]       rr_next;
  logic [NUM_REQ-1:0]    gnt;
  logic                  granted;
  logic                  s1_vld;
  logic [ID_W-1:0]       s1_id;
  logic [NUM_REQ-1:0]    resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;

  // Search starts at rr_ptr and wraps; the first valid port wins.
  always_comb begin
    logic [ID_W-1:0] cand;
    cand    = '0;
    gnt     = '0;
    gnt_id  = '0;
    granted = 1'b0;
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
        if (!granted && bus.req_valid[cand]) begin
          granted = 1'b1;
          gnt_id  = cand;
        end
      end
    end
    if (granted) gnt[gnt_id] = 1'b1;
  end

  always_comb begin
    rr_next = (32'(gnt_id) == 32'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  assign bus.req_ready  = gnt;
  assign sram_addr      = bus.req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign sram_data      = bus.req_wdata[gnt_id*DATA_WIDTH +: DATA_WIDTH];
  assign sram_write_req = granted & bus.req_write[gnt_id];

  // Stage 1 tracks the read while the SRAM produces q; stage 2 registers q.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      s1_vld       <= 1'b0;
      s1_id        <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      if (granted) rr_ptr <= rr_next;
      s1_vld       <= granted & ~bus.req_write[gnt_id];
      s1_id        <= gnt_id;
      resp_valid_q <= s1_vld ? (NUM_REQ'(1) << s1_id) : '0;
      if (s1_vld) resp_rdata_q <= sram_q;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus predicts grants and read data,
// a negedge monitor pops expectations and compares against the DUT.
module tb_sram_arbiter;
  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data;
  logic [DW-1:0] sram_q;
  logic          sram_write_req;

  sram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .sram_addr      (sram_addr),
    .sram_data      (sram_data),
    .sram_write_req (sram_write_req),
    .sram_q         (sram_q)
  );

  // Single-port SRAM behavioural model, 1-cycle read latency.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (sram_write_req) mem[sram_addr] <= sram_data;
    sram_q <= mem[sram_addr];
  end

  logic [N-1:0]  v = '0;
  logic [N-1:0]  w = '0;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];

  always_comb begin
    bus.req_valid = v;
    bus.req_write = w;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = a[i];
      bus.req_wdata[i*DW +: DW] = d[i];
    end
  end

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  typedef struct {
    logic [N-1:0]  ready;
    logic          wr;
    int            g;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            has_hand;
    logic [N-1:0]  hand_ready;
  } cyc_t;

  rsp_t sbq [$];
  cyc_t cq  [$];

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  bit            armed = 1'b0;
  bit            end_req = 1'b0;
  bit            end_done = 1'b0;
  int unsigned   m_ptr = 0;
  logic [DW-1:0] ref_mem [256];
  logic [N-1:0]  m_last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of one cycle: predicts grant, SRAM drive and read data.
  task automatic issue(input bit hr_en, input logic [N-1:0] hr,
                       input bit hd_en, input logic [DW-1:0] hd);
    cyc_t c;
    int   g;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (int'(m_ptr) + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    c.g          = g;
    c.ready      = (g < 0) ? '0 : (N'(1) << g);
    c.wr         = (g >= 0) ? w[g] : 1'b0;
    c.addr       = (g >= 0) ? a[g] : '0;
    c.data       = (g >= 0) ? d[g] : '0;
    c.has_hand   = hr_en;
    c.hand_ready = hr;
    cq.push_back(c);
    if (rst) begin
      m_ptr = 0;
      while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
    end else if (g >= 0) begin
      m_ptr = unsigned'((g + 1) % N);
      if (w[g]) ref_mem[a[g]] = d[g];
      else sbq.push_back('{g, hd_en ? hd : ref_mem[a[g]], cyc + 2});
    end
    m_last = c.ready;
    armed  = 1'b1;
  endtask

  task automatic drive_cycle(input logic r, input logic [N-1:0] vv, ww,
                             input logic [AW-1:0] a0, a1,
                             input logic [DW-1:0] d0, d1,
                             input bit hr_en, input logic [N-1:0] hr,
                             input bit hd_en, input logic [DW-1:0] hd);
    @(posedge clk); #1;
    rst = r; v = vv; w = ww;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    issue(hr_en, hr, hd_en, hd);
  endtask

  int wait_cnt [N];

  always @(negedge clk) begin : monitor
    cyc_t c;
    rsp_t r;
    if (armed) begin
      if (cq.size() > 0) begin
        c = cq.pop_front();
        checks++;
        if (bus.req_ready !== c.ready) begin
          errors++;
          $display("FAIL req_ready cyc=%0d: got %b want %b", cyc, bus.req_ready, c.ready);
        end
        checks++;
        if (sram_write_req !== c.wr) begin
          errors++;
          $display("FAIL write_req cyc=%0d: got %b want %b", cyc, sram_write_req, c.wr);
        end
        if (c.g >= 0) begin
          checks++;
          if (sram_addr !== c.addr) begin
            errors++;
            $display("FAIL sram_addr cyc=%0d: got %h want %h", cyc, sram_addr, c.addr);
          end
        end
        if (c.wr) begin
          checks++;
          if (sram_data !== c.data) begin
            errors++;
            $display("FAIL sram_data cyc=%0d: got %h want %h", cyc, sram_data, c.data);
          end
        end
        if (c.has_hand) begin
          checks++;
          if (bus.req_ready !== c.hand_ready) begin
            errors++;
            $display("FAIL grant_order cyc=%0d: got %b want %b", cyc, bus.req_ready, c.hand_ready);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (v[i] && !rst && bus.req_ready[i] !== 1'b1) begin
          wait_cnt[i]++;
          checks++;
          if (wait_cnt[i] > N - 1) begin
            errors++;
            $display("FAIL starvation port%0d cyc=%0d: waited %0d want <= %0d", i, cyc, wait_cnt[i], N - 1);
          end
        end else begin
          wait_cnt[i] = 0;
        end
      end
      if (bus.resp_valid !== '0) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp cyc=%0d: got resp_valid %b want 0", cyc, bus.resp_valid);
        end else begin
          r = sbq.pop_front();
          if (bus.resp_valid !== (N'(1) << r.port) || bus.resp_rdata !== r.data || r.due != cyc) begin
            errors++;
            $display("FAIL resp cyc=%0d: got valid %b data %h want valid %b data %h at cyc %0d",
                     cyc, bus.resp_valid, bus.resp_rdata, N'(1) << r.port, r.data, r.due);
          end
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        r = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_resp cyc=%0d: got no response want port%0d data %h", cyc, r.port, r.data);
      end
      if (end_req && !end_done) begin
        checks++;
        if (sbq.size() != 0) begin
          errors++;
          $display("FAIL drain: got %0d outstanding reads want 0", sbq.size());
        end
        end_done = 1'b1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      a[i] = '0; d[i] = '0; wait_cnt[i] = 0;
    end

    // Reset held with every port requesting writes.
    repeat (2) drive_cycle(1, 2'b11, 2'b11, 8'h10, 8'h20, 64'h1, 64'h2, 1, 2'b00, 0, '0);

    // Write then immediate read-back on port 0.
    drive_cycle(0, 2'b01, 2'b01, 8'h10, 8'h00, 64'hDEADBEEF, '0, 1, 2'b01, 0, '0);
    drive_cycle(0, 2'b01, 2'b00, 8'h10, 8'h00, '0, '0, 1, 2'b01, 1, 64'hDEADBEEF);
    drive_cycle(0, 2'b01, 2'b01, 8'h01, 8'h00, 64'h1111, '0, 1, 2'b01, 0, '0);
    drive_cycle(0, 2'b10, 2'b10, 8'h00, 8'h02, '0, 64'h2222, 1, 2'b10, 0, '0);

    // Continuous reads from both ports alternate.
    for (int k = 0; k < 6; k++)
      drive_cycle(0, 2'b11, 2'b00, 8'h01, 8'h02, '0, '0, 1,
                  (k % 2 == 0) ? 2'b01 : 2'b10, 1, (k % 2 == 0) ? 64'h1111 : 64'h2222);

    // Pointer wraps after a grant to the last port.
    drive_cycle(0, 2'b10, 2'b00, 8'h00, 8'h02, '0, '0, 1, 2'b10, 1, 64'h2222);
    drive_cycle(0, 2'b11, 2'b00, 8'h01, 8'h02, '0, '0, 1, 2'b01, 1, 64'h1111);

    // Reset one cycle after a read grant drops the read.
    drive_cycle(0, 2'b01, 2'b00, 8'h01, 8'h00, '0, '0, 1, 2'b01, 1, 64'h1111);
    drive_cycle(1, 2'b00, 2'b00, 8'h00, 8'h00, '0, '0, 1, 2'b00, 0, '0);
    for (int k = 0; k < 4; k++)
      drive_cycle(0, 2'b11, 2'b00, 8'h01, 8'h02, '0, '0, 1,
                  (k % 2 == 0) ? 2'b01 : 2'b10, 1, (k % 2 == 0) ? 64'h1111 : 64'h2222);
    repeat (3) drive_cycle(0, 2'b00, 2'b00, 8'h00, 8'h00, '0, '0, 0, '0, 0, '0);

    // Random traffic; an ungranted request is held unchanged.
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!(v[i] && !m_last[i])) begin
          v[i] = ($urandom_range(0, 3) != 0);
          w[i] = ($urandom_range(0, 2) == 0);
          a[i] = AW'($urandom_range(0, 15));
          d[i] = {$urandom, $urandom};
        end
      end
      issue(0, '0, 0, '0);
    end

    repeat (4) drive_cycle(0, 2'b00, 2'b00, 8'h00, 8'h00, '0, '0, 0, '0, 0, '0);
    end_req = 1'b1;
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
